// File: rtl/scurve_pulse_gen.sv
// scurve_pulse_gen: charge-injection pulse generator driving CLK_EXT for the
// S-curve counter. Emits Pulse_Max pulses with programmable high/low widths.
// Optional feature macro: SCURVE_PULSE_GEN_CPT_STOP_EN
//   defined   -> Cpt_Done sampled in LOW ends the run early (DONE)
//   undefined -> Cpt_Done is ignored; exactly Pulse_Max pulses are emitted
module scurve_pulse_gen #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             Test_Start,
  input  logic [CNT_W-1:0] Pulse_Max,
  input  logic [CNT_W-1:0] High_Width,
  input  logic [CNT_W-1:0] Low_Width,
  input  logic             Cpt_Done,
  output logic             CLK_EXT,
  output logic [CNT_W-1:0] Pulse_Count,
  output logic             Gen_Busy,
  output logic             Gen_Done
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             clk_ext_q, clk_ext_d;
  logic [CNT_W-1:0] pulse_count_q, pulse_count_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] pulse_max_q, pulse_max_d;
  logic [CNT_W-1:0] high_w_q, high_w_d;
  logic [CNT_W-1:0] low_w_q, low_w_d;
  logic             cpt_stop;

`ifdef SCURVE_PULSE_GEN_CPT_STOP_EN
  assign cpt_stop = Cpt_Done;
`else
  logic unused_cpt_done;
  assign unused_cpt_done = Cpt_Done;
  assign cpt_stop        = 1'b0;
`endif

  // State, pulse output and counters; reset drops CLK_EXT immediately
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      clk_ext_q     <= 1'b0;
      pulse_count_q <= ZERO;
      phase_q       <= ZERO;
      pulse_max_q   <= ZERO;
      high_w_q      <= ONE;
      low_w_q       <= ONE;
    end else begin
      state_q       <= state_d;
      clk_ext_q     <= clk_ext_d;
      pulse_count_q <= pulse_count_d;
      phase_q       <= phase_d;
      pulse_max_q   <= pulse_max_d;
      high_w_q      <= high_w_d;
      low_w_q       <= low_w_d;
    end
  end

  // Next-state logic: configuration is captured (with 0 widths promoted to 1)
  // only when leaving IDLE, so a run never sees its parameters change
  always_comb begin
    state_d       = state_q;
    clk_ext_d     = clk_ext_q;
    pulse_count_d = pulse_count_q;
    phase_d       = phase_q;
    pulse_max_d   = pulse_max_q;
    high_w_d      = high_w_q;
    low_w_d       = low_w_q;

    case (state_q)
      ST_IDLE: begin
        clk_ext_d = 1'b0;
        if (Test_Start) begin
          pulse_max_d = Pulse_Max;
          high_w_d    = (High_Width == ZERO) ? ONE : High_Width;
          low_w_d     = (Low_Width == ZERO) ? ONE : Low_Width;
          if (Pulse_Max != ZERO) begin
            state_d       = ST_HIGH;
            clk_ext_d     = 1'b1;
            pulse_count_d = ONE;
            phase_d       = ONE;
          end else begin
            state_d       = ST_DONE;
            pulse_count_d = ZERO;
          end
        end
      end

      ST_HIGH: begin
        if (!Test_Start) begin
          state_d   = ST_IDLE;
          clk_ext_d = 1'b0;
        end else if (phase_q == high_w_q) begin
          state_d   = ST_LOW;
          clk_ext_d = 1'b0;
          phase_d   = ONE;
        end else begin
          phase_d = phase_q + ONE;
        end
      end

      ST_LOW: begin
        if (!Test_Start) begin
          state_d   = ST_IDLE;
          clk_ext_d = 1'b0;
        end else if (cpt_stop) begin
          state_d   = ST_DONE;
          clk_ext_d = 1'b0;
        end else if (phase_q == low_w_q) begin
          if (pulse_count_q == pulse_max_q) begin
            state_d   = ST_DONE;
            clk_ext_d = 1'b0;
          end else begin
            state_d       = ST_HIGH;
            clk_ext_d     = 1'b1;
            pulse_count_d = pulse_count_q + ONE;
            phase_d       = ONE;
          end
        end else begin
          phase_d = phase_q + ONE;
        end
      end

      ST_DONE: begin
        clk_ext_d = 1'b0;
        if (!Test_Start) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_ext_d = 1'b0;
      end
    endcase
  end

  assign CLK_EXT     = clk_ext_q;
  assign Pulse_Count = pulse_count_q;
  assign Gen_Busy    = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign Gen_Done    = (state_q == ST_DONE);

endmodule

// File: doc/scurve_pulse_gen.md
# scurve_pulse_gen

Charge-injection pulse generator for the S-curve test; the transmitting end of the `CLK_EXT` interface that the S-curve counter samples. On `Test_Start` it emits a programmed number of `CLK_EXT` pulses. Each pulse has a programmable high and low width in `Clk` cycles. In trigger-efficiency mode the counter uses the high phase as its trigger window. Generation stops early when the counter reports `Cpt_Done`, and completion is flagged back to the top-level sweep controller.

## Interface
Parameters:
- `CNT_W`, default 16: width of the width, period and pulse counters.

Ports:
- `Clk`, input, 1: system clock. All logic is on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset. This is the only reset.
- `Test_Start`, input, 1: level run request. 1 = run; dropping it to 0 aborts.
- `Pulse_Max`, input, CNT_W: number of pulses to emit. Matches the counter's `CPT_MAX`.
- `High_Width`, input, CNT_W: `CLK_EXT` high time in `Clk` cycles. A value of 0 is treated as 1.
- `Low_Width`, input, CNT_W: `CLK_EXT` low time in `Clk` cycles. A value of 0 is treated as 1.
- `Cpt_Done`, input, 1: done flag from the counter, synchronous to `Clk`.
- `CLK_EXT`, output, 1: registered injection pulse train.
- `Pulse_Count`, output, CNT_W: number of pulses emitted in the current or last run.
- `Gen_Busy`, output, 1: high in the HIGH and LOW states.
- `Gen_Done`, output, 1: level; high in the DONE state.

## Operation
- Reset values: state = IDLE; `CLK_EXT` = 0; `Pulse_Count` = 0; `Gen_Busy` = 0; `Gen_Done` = 0; phase counter = 0.
- Configuration inputs are latched on the IDLE→HIGH or IDLE→DONE transition and stay constant for the whole run.
- States: IDLE, HIGH, LOW, DONE.
- **IDLE**
  - `Test_Start`=1 and latched `Pulse_Max`≠0 → HIGH. On the same edge: `CLK_EXT`←1, `Pulse_Count`←1, phase counter←1.
  - `Test_Start`=1 and `Pulse_Max`=0 → DONE. `Pulse_Count`←0.
- **HIGH**
  - When the phase counter equals the effective `High_Width` → LOW. `CLK_EXT`←0, phase counter←1.
  - Otherwise the phase counter increments.
  - `Cpt_Done` is ignored in HIGH, so the counter never sees a truncated window.
- **LOW**
  - When the phase counter equals the effective `Low_Width`:
    - if `Pulse_Count` = latched `Pulse_Max` → DONE;
    - otherwise → HIGH, with `CLK_EXT`←1, `Pulse_Count`+1, phase counter←1.
  - Otherwise the phase counter increments.
- **DONE**
  - `CLK_EXT` = 0 and `Gen_Done` = 1.
  - `Test_Start`=0 → IDLE. `Pulse_Count` holds its value until the next start.
- **Abort**
  - `Test_Start`=0 in HIGH or LOW → IDLE on the next edge, with `CLK_EXT`←0. Pulse width is not preserved on abort.
  - `Gen_Done` is not raised on abort.
  - `Pulse_Count` holds until the next start.
- **Arithmetic**
  - Phase counter and `Pulse_Count` are unsigned CNT_W bits.
  - `Pulse_Count` never exceeds `Pulse_Max`, so no wrap is possible.
  - Maximum high or low width is 2^CNT_W−1 cycles.

## Timing
- Start latency: `CLK_EXT` rises at the first `Clk` edge where IDLE samples `Test_Start`=1.
- High phase lasts exactly eff(`High_Width`) cycles; low phase lasts exactly eff(`Low_Width`) cycles. Period = sum of the two.
- Total run, with no early stop: `Pulse_Max` × period cycles from the first rising edge of `CLK_EXT` to entry into DONE.
- `Gen_Done` rises on the same edge as DONE entry.
- `Test_Start`=0 in DONE: `Gen_Done` falls on the next edge.
- Cpt_Done early stop (only when the macro below is defined): `Cpt_Done`=1 sampled in LOW → DONE on that edge, even if the low phase or the pulse budget is unfinished.
- Simultaneous end of the low phase and `Cpt_Done`=1 → DONE. No new pulse is started.
- `reset_n` low at any time: all outputs take their reset values asynchronously. `CLK_EXT` drops immediately.

## Configuration
- Macro: `SCURVE_PULSE_GEN_CPT_STOP_EN`.
- Defined: `Cpt_Done` in LOW forces DONE, as described under Timing.
- Undefined: `Cpt_Done` is ignored and the run always emits exactly `Pulse_Max` pulses. The port remains present.

## Test plan
- Reset, then `Test_Start`=1 with `Pulse_Max`=3, `High_Width`=4, `Low_Width`=6 → 3 pulses of 4 high / 6 low cycles; `Pulse_Count`=3; `Gen_Done`=1 exactly 30 cycles after the first rise; `Gen_Done`=0 one cycle after `Test_Start`=0.
- `High_Width`=0, `Low_Width`=0, `Pulse_Max`=2 → pulse train of 1 high / 1 low cycle; 2 rising edges; DONE after 4 cycles.
- `Pulse_Max`=0 → `CLK_EXT` stays 0; `Gen_Done`=1 one cycle after start; `Pulse_Count`=0.
- Macro defined, `Pulse_Max`=100, `Cpt_Done` pulsed during the LOW phase of pulse 5 → DONE on that edge; `Pulse_Count`=5; no 6th rising edge. Macro undefined, same stimulus → 100 pulses.
- `Test_Start` dropped mid-HIGH of pulse 2 → `CLK_EXT`=0 next edge; IDLE; `Gen_Done` stays 0; a restart resets `Pulse_Count` to 1.
- `reset_n` asserted during HIGH → `CLK_EXT`, `Pulse_Count`, `Gen_Busy` and `Gen_Done` go to 0 without waiting for a clock edge.
